// File: rtl/piece_gravity_if.sv
// Signal bundle between the gravity controller and the board/piece datapath.
// master = controller side, slave = datapath / collision checker / board writer side.
interface piece_gravity_if #(
    parameter int ROWS_W = 5
);
    logic              piece_clk;
    logic              drop;
    logic              active;
    // chk_req is a level request held until the checker answers with a one-cycle
    // chk_ack; chk_blocked is meaningful only in the chk_ack cycle. lock is a
    // one-cycle command answered later by a one-cycle lock_done.
    logic              chk_req;
    logic              chk_ack;
    logic              chk_blocked;
    logic              move_down;
    logic              lock;
    logic              lock_done;
    logic [ROWS_W-1:0] soft_rows;
    logic              grounded;

    modport master (
        input  piece_clk, drop, active, chk_ack, chk_blocked, lock_done,
        output chk_req, move_down, lock, soft_rows, grounded
    );

    modport slave (
        output piece_clk, drop, active, chk_ack, chk_blocked, lock_done,
        input  chk_req, move_down, lock, soft_rows, grounded
    );
endinterface

// File: rtl/piece_gravity_ctrl.sv
// Fall-step sequencer for the active piece: gravity tick -> collision check ->
// move down, or lock delay -> board lock. Also counts soft-dropped rows.
module piece_gravity_ctrl #(
    parameter int LOCK_DELAY = 15000000,
    parameter int CNT_W      = 26,
    parameter int ROWS_W     = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    piece_gravity_if.master   bus,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        CHECK     = 3'd2,
        GROUNDED  = 3'd3,
        GCHECK    = 3'd4,
        LOCKING   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_DELAY - 1);
    localparam logic [ROWS_W-1:0] ROWS_MAX  = '1;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              chk_req_q, chk_req_n;
    logic              move_down_q, move_down_n;
    logic              lock_q, lock_n;
    logic              grounded_q, grounded_n;
    logic [ROWS_W-1:0] soft_rows_q, soft_rows_n;

    logic              lock_due;
    logic [CNT_W-1:0]  cnt_inc;
    logic [ROWS_W-1:0] soft_inc;
    logic              in_play;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            chk_req_q   <= 1'b0;
            move_down_q <= 1'b0;
            lock_q      <= 1'b0;
            grounded_q  <= 1'b0;
            soft_rows_q <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            chk_req_q   <= chk_req_n;
            move_down_q <= move_down_n;
            lock_q      <= lock_n;
            grounded_q  <= grounded_n;
            soft_rows_q <= soft_rows_n;
        end
    end

    // The counter saturates at LOCK_LAST so a slow GCHECK handshake cannot wrap it.
    assign lock_due = (cnt >= LOCK_LAST) || bus.drop;
    assign cnt_inc  = (cnt >= LOCK_LAST) ? cnt : cnt + CNT_W'(1);
    assign soft_inc = (bus.drop && (soft_rows_q != ROWS_MAX)) ? soft_rows_q + ROWS_W'(1)
                                                              : soft_rows_q;
    assign in_play  = (state == WAIT_TICK) || (state == CHECK) ||
                      (state == GROUNDED)  || (state == GCHECK);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        chk_req_n   = chk_req_q;
        move_down_n = 1'b0;
        lock_n      = 1'b0;
        grounded_n  = grounded_q;
        soft_rows_n = soft_rows_q;

        case (state)
            IDLE: begin
                chk_req_n  = 1'b0;
                grounded_n = 1'b0;
                cnt_n      = '0;
                if (bus.active) begin
                    state_n     = WAIT_TICK;
                    soft_rows_n = '0;
                end
            end
            WAIT_TICK: begin
                if (bus.piece_clk) begin
                    state_n   = CHECK;
                    chk_req_n = 1'b1;
                end
            end
            CHECK: begin
                if (bus.chk_ack) begin
                    chk_req_n = 1'b0;
                    if (bus.chk_blocked) begin
                        cnt_n      = '0;
                        grounded_n = 1'b1;
                        if (bus.drop) begin
                            state_n = LOCKING;
                            lock_n  = 1'b1;
                        end else begin
                            state_n = GROUNDED;
                        end
                    end else begin
                        move_down_n = 1'b1;
                        soft_rows_n = soft_inc;
                        state_n     = WAIT_TICK;
                    end
                end
            end
            GROUNDED: begin
                if (lock_due) begin
                    state_n = LOCKING;
                    lock_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                    if (bus.piece_clk) begin
                        state_n   = GCHECK;
                        chk_req_n = 1'b1;
                    end
                end
            end
            GCHECK: begin
                cnt_n = cnt_inc;
                if (bus.chk_ack) begin
                    chk_req_n = 1'b0;
                    if (bus.chk_blocked) begin
                        if (lock_due) begin
                            state_n = LOCKING;
                            lock_n  = 1'b1;
                            cnt_n   = '0;
                        end else begin
                            state_n = GROUNDED;
                        end
                    end else begin
                        // Slid off a ledge: falling resumes with a fresh lock delay later.
                        move_down_n = 1'b1;
                        soft_rows_n = soft_inc;
                        cnt_n       = '0;
                        grounded_n  = 1'b0;
                        state_n     = WAIT_TICK;
                    end
                end
            end
            LOCKING: begin
                grounded_n = 1'b1;
                if (bus.lock_done) begin
                    state_n    = IDLE;
                    grounded_n = 1'b0;
                    cnt_n      = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Losing the piece aborts any step in progress; soft_rows is kept for scoring.
        if (in_play && !bus.active) begin
            state_n     = IDLE;
            cnt_n       = '0;
            chk_req_n   = 1'b0;
            move_down_n = 1'b0;
            lock_n      = 1'b0;
            grounded_n  = 1'b0;
            soft_rows_n = soft_rows_q;
        end
    end

    assign bus.chk_req   = chk_req_q;
    assign bus.move_down = move_down_q;
    assign bus.lock      = lock_q;
    assign bus.grounded  = grounded_q;
    assign bus.soft_rows = soft_rows_q;
    assign state_dbg     = state;

endmodule
